// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared word/opcode definitions for the ALU and operand fetch stage
package operand_fetch_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int ALUOP_SIZE = 4;
    localparam int REG_BITS   = 4;

    typedef enum logic [ALUOP_SIZE-1:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_NOT   = 4'h5,
        ALU_SHL   = 4'h6,
        ALU_SHR   = 4'h7,
        ALU_ADDF  = 4'h8,
        ALU_MULF  = 4'h9,
        ALU_FLOAT = 4'ha,
        ALU_INT   = 4'hb,
        ALU_NEG   = 4'hc,
        ALU_NEGF  = 4'hd,
        ALU_RECIP = 4'he,
        ALU_PASS  = 4'hf
    } aluop_t;

endpackage

// File: rtl/operand_fetch_regfile_sb.sv
// rtl/operand_fetch_regfile_sb.sv - register file with busy-bit scoreboard and writeback bypass
module regfile_sb
    import operand_fetch_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_BITS-1:0]  rd_addr,
    input  logic [REG_BITS-1:0]  rs_addr,
    input  logic                 useb,
    input  logic                 set_en,
    input  logic                 wb_en,
    input  logic [REG_BITS-1:0]  wb_reg,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic [WORD_SIZE-1:0] a_data,
    output logic [WORD_SIZE-1:0] b_data,
    output logic                 hazard
);

    logic [WORD_SIZE-1:0] regs [NREGS];
    logic [NREGS-1:0]     busy;
    logic                 wb_hit_rd;
    logic                 wb_hit_rs;

    // A writeback landing this cycle both forwards its data and lifts the stall.
    always_comb begin
        wb_hit_rd = wb_en && (wb_reg == rd_addr);
        wb_hit_rs = wb_en && (wb_reg == rs_addr);
        a_data    = wb_hit_rd ? wb_data : regs[rd_addr];
        b_data    = '0;
        if (useb) begin
            b_data = wb_hit_rs ? wb_data : regs[rs_addr];
        end
        hazard = (busy[rd_addr] && !wb_hit_rd) ||
                 (useb && busy[rs_addr] && !wb_hit_rs);
    end

    // The set is written after the clear so a new in-flight write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_en) begin
                regs[wb_reg] <= wb_data;
                busy[wb_reg] <= 1'b0;
            end
            if (set_en) begin
                busy[rd_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage: hazard-checked register read into a registered ALU handoff
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALUOP_SIZE-1:0] in_op,
    input  logic [REG_BITS-1:0]   in_rd,
    input  logic [REG_BITS-1:0]   in_rs,
    input  logic                  in_useb,
    input  logic                  in_wr,
    input  logic                  wb_en,
    input  logic [REG_BITS-1:0]   wb_reg,
    input  logic [WORD_SIZE-1:0]  wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALUOP_SIZE-1:0] out_op,
    output logic [WORD_SIZE-1:0]  out_a,
    output logic [WORD_SIZE-1:0]  out_b,
    output logic [REG_BITS-1:0]   out_rd,
    output logic                  out_wr
);

    logic                 hazard;
    logic                 accept;
    logic [WORD_SIZE-1:0] a_data;
    logic [WORD_SIZE-1:0] b_data;

    assign in_ready = !reset && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    regfile_sb #(.NREGS(NREGS)) u_regfile_sb (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (in_rd),
        .rs_addr (in_rs),
        .useb    (in_useb),
        .set_en  (accept && in_wr),
        .wb_en   (wb_en),
        .wb_reg  (wb_reg),
        .wb_data (wb_data),
        .a_data  (a_data),
        .b_data  (b_data),
        .hazard  (hazard)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
            out_wr    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_a     <= a_data;
            out_b     <= b_data;
            out_rd    <= in_rd;
            out_wr    <= in_wr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch against a register/busy reference model
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [3:0]  in_rd = '0;
    logic [3:0]  in_rs = '0;
    logic        in_useb = 1'b0;
    logic        in_wr = 1'b0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_reg = '0;
    logic [15:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_op;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [3:0]  out_rd;
    logic        out_wr;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rd;
        logic        wr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_r [16];
    logic [15:0] m_busy = '0;
    logic        m_ov = 1'b0;
    int          checks = 0;
    int          errors = 0;

    operand_fetch #(.NREGS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_useb   (in_useb),
        .in_wr     (in_wr),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_rd    (out_rd),
        .out_wr    (out_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, predict in_ready from the model, then advance the model.
    task automatic step(input logic rst, input logic v, input logic [3:0] op,
                        input logic [3:0] rd, input logic [3:0] rs, input logic useb,
                        input logic wr, input logic wbe, input logic [3:0] wbr,
                        input logic [15:0] wbd, input logic ordy);
        logic hz;
        logic rdy;
        logic acc;
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; in_valid = v; in_op = op; in_rd = rd; in_rs = rs;
        in_useb = useb; in_wr = wr; wb_en = wbe; wb_reg = wbr; wb_data = wbd;
        out_ready = ordy;
        #1;
        hz  = (m_busy[rd] && !(wbe && wbr == rd)) || (useb && m_busy[rs] && !(wbe && wbr == rs));
        rdy = !rst && (!m_ov || ordy) && !hz;
        acc = v && rdy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (rst) begin
            for (int i = 0; i < 16; i++) m_r[i] = '0;
            m_busy = '0;
            m_ov   = 1'b0;
            exp_q.delete();
        end else begin
            if (acc) begin
                e.op = op;
                e.a  = (wbe && wbr == rd) ? wbd : m_r[rd];
                e.b  = !useb ? 16'h0 : ((wbe && wbr == rs) ? wbd : m_r[rs]);
                e.rd = rd;
                e.wr = wr;
                exp_q.push_back(e);
            end
            if (wbe) begin
                m_r[wbr]    = wbd;
                m_busy[wbr] = 1'b0;
            end
            if (acc && wr) m_busy[rd] = 1'b1;
            if (acc) m_ov = 1'b1;
            else if (ordy) m_ov = 1'b0;
        end
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 16'h0, 1);
    endtask

    task automatic wb(input logic [3:0] r, input logic [15:0] d);
        step(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, r, d, 1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic useb, input logic wr);
        step(0, 1, op, rd, rs, useb, wr, 0, 4'h0, 16'h0, 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 64'(out_valid), 64'(0));
                end else begin
                    chk("out_fields", 64'({out_op, out_a, out_b, out_rd, out_wr}), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] busy_list[$];
        logic [3:0] wr_sel;
        logic       wbe;

        step(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h5, 16'hdead, 1);
        step(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 16'h0, 1);
        chk("reset_out_regs", 64'({out_op, out_a, out_b, out_rd, out_wr}), 64'(0));

        // simple path
        wb(4'd1, 16'h0004);
        wb(4'd2, 16'h0007);
        issue(ALU_ADD, 4'd1, 4'd2, 1, 0);
        idle();
        chk("simple_valid", 64'(out_valid), 64'(1));
        chk("simple_a", 64'(out_a), 64'h0004);
        chk("simple_b", 64'(out_b), 64'h0007);
        chk("simple_rd", 64'(out_rd), 64'd1);

        // hazard stall released by writeback bypass
        issue(ALU_ADD, 4'd3, 4'd0, 0, 1);
        step(0, 1, ALU_ADD, 4'd3, 4'd2, 1, 0, 0, 4'h0, 16'h0, 1);
        chk("stall_ready", 64'(in_ready), 64'(0));
        step(0, 1, ALU_ADD, 4'd3, 4'd2, 1, 0, 0, 4'h0, 16'h0, 1);
        step(0, 1, ALU_ADD, 4'd3, 4'd2, 1, 0, 1, 4'd3, 16'h3f80, 1);
        chk("bypass_ready", 64'(in_ready), 64'(1));
        idle();
        chk("bypass_a", 64'(out_a), 64'h3f80);

        // backpressure
        issue(ALU_SUB, 4'd6, 4'd1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, ALU_ADD, 4'd1, 4'd2, 1, 0, 0, 4'h0, 16'h0, 0);
            chk("bp_ready", 64'(in_ready), 64'(0));
        end
        step(0, 1, ALU_ADD, 4'd1, 4'd2, 1, 0, 0, 4'h0, 16'h0, 1);
        chk("bp_release_ready", 64'(in_ready), 64'(1));

        // unary op ignores busy rs
        issue(ALU_ADD, 4'd7, 4'd0, 0, 1);
        issue(ALU_NEG, 4'd5, 4'd7, 0, 0);
        chk("unary_ready", 64'(in_ready), 64'(1));
        idle();
        chk("unary_b", 64'(out_b), 64'h0);

        // simultaneous set and clear of busy[4]
        issue(ALU_ADD, 4'd4, 4'd0, 0, 1);
        step(0, 1, ALU_ADD, 4'd4, 4'd0, 0, 1, 1, 4'd4, 16'h1234, 1);
        chk("setclr_ready", 64'(in_ready), 64'(1));
        step(0, 1, ALU_OR, 4'd4, 4'd0, 0, 0, 0, 4'h0, 16'h0, 1);
        chk("setclr_stall", 64'(in_ready), 64'(0));

        // reset mid-stream
        step(0, 1, ALU_ADD, 4'd1, 4'd0, 0, 1, 0, 4'h0, 16'h0, 0);
        step(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 16'h0, 0);
        step(1, 1, ALU_ADD, 4'd2, 4'd0, 0, 1, 1, 4'd9, 16'hbeef, 0);
        idle();
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        issue(ALU_ADD, 4'd1, 4'd4, 1, 0);
        chk("rst_mid_ready", 64'(in_ready), 64'(1));
        idle();
        chk("rst_mid_a", 64'(out_a), 64'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            busy_list.delete();
            for (int i = 0; i < 16; i++) if (m_busy[i]) busy_list.push_back(4'(i));
            wbe    = ($urandom % 2) == 1;
            wr_sel = 4'($urandom);
            if (wbe && busy_list.size() > 0 && ($urandom % 4) != 0)
                wr_sel = busy_list[$urandom % busy_list.size()];
            step(($urandom % 300) == 0, ($urandom % 4) != 0, 4'($urandom), 4'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), wbe, wr_sel, 16'($urandom),
                 ($urandom % 4) != 0);
        end

        for (int i = 0; i < 20; i++) idle();
        @(negedge clk);
        #1;
        chk("drain_queue", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
